triple_reg_shuffler: RTL and testbench
======================================

Name: triple_reg_shuffler

Overview:
- Sequential consumer of a three-word (a, b, c) 32-bit register triple.
- Captures a triple through a valid/ready handshake, then applies a selected register-transfer operation once per clock for a programmable number of steps.
- Presents the resulting triple with a valid/ready output handshake.
- Gives the team a deterministic, clocked home for the a/b/c transfer patterns used in the assignment-semantics experiments.

Parameters:
- WIDTH, 32, bit width of each of a, b, c.
- CNT_W, 8, bit width of the step count.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high; clears all state.
- in_valid  input  1  upstream offers a triple.
- in_ready  output  1  block accepts a triple; high only in IDLE.
- in_a / in_b / in_c  input  WIDTH  triple to load.
- op  input  2  operation, sampled at accept.
- steps  input  CNT_W  number of op applications, sampled at accept.
- out_valid  output  1  result triple valid; high only in DONE.
- out_ready  input  1  downstream takes the result.
- out_a / out_b / out_c  output  WIDTH  current internal triple, always driven.
- busy  output  1  high in RUN.
- step_cnt  output  CNT_W  remaining steps; 0 outside RUN.

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - state = IDLE.
  - out_a = out_b = out_c = 0.
  - step_cnt = 0, latched op = 0.
  - in_ready = 1, out_valid = 0, busy = 0.
- Reset asserted mid-RUN or mid-DONE aborts the operation. No partial result is ever flagged valid.
- States: IDLE, RUN, DONE. One-hot or binary encoding; illegal encodings recover to IDLE.
- IDLE:
  - in_ready = 1.
  - When in_valid is high at a rising edge: load (in_a, in_b, in_c) into the triple and latch op.
  - If steps == 0, go to DONE; otherwise step_cnt = steps and go to RUN.
  - in_valid low: hold.
- RUN:
  - Every rising edge applies the latched op to the triple, all three words updated simultaneously from pre-edge values, and decrements step_cnt.
  - When step_cnt == 1 at the edge, apply the final op, set step_cnt = 0 and go to DONE.
  - in_ready = 0; in_valid is ignored.
- Operations (pre-edge values on the right):
  - op=00 rotate-left: a<=b, b<=c, c<=a.
  - op=01 rotate-right: a<=c, b<=a, c<=b.
  - op=10 shift-chain: a<=b, b<=c, c holds.
  - op=11 swap-ends: a<=c, c<=a, b holds.
- DONE:
  - out_valid = 1; the triple holds.
  - When out_ready is high at a rising edge, go to IDLE.
  - out_ready low stalls indefinitely with the triple stable.
  - in_ready = 0, so no accept can coincide with the DONE->IDLE edge.
- Latency: accept edge k; out_valid is high after edge k+steps.
  - steps = 0: out_valid after edge k.
  - Maximum steps = 2^CNT_W - 1; no wrap, since the counter only decrements from a nonzero value to 0.
- out_* in IDLE show the last result. This is informational only and not qualified by out_valid.
- op and steps changing during RUN/DONE have no effect.
- No arithmetic; pure register transfers, no width growth.

Test Plan:
- Reset, then load (1,0,1), op=00, steps=1 -> after 1 RUN edge out_valid=1, triple (0,1,1); out_ready=1 -> IDLE, in_ready=1.
- Load (1,2,3), op=00, steps=3 -> triple (1,2,3), out_valid 3 edges after accept; op=01, steps=1 -> (3,1,2).
- Load (1,0,1), op=10, steps=2 -> (1,1,1); op=11, steps=1 on (1,2,3) -> (3,2,1).
- steps=0, load (7,8,9) -> out_valid after the accept edge, triple (7,8,9); hold out_ready=0 for 5 cycles -> out_valid=1 and triple unchanged; in_valid=1 meanwhile is not accepted.
- Load (1,2,3), op=00, steps=200; assert reset between edges at step_cnt=150 -> immediately outputs 0, state IDLE, out_valid=0; after release a new accept works normally.
- steps=255, op=00 -> out_valid exactly 255 edges after accept, triple = rotate-left^(255 mod 3 = 0) = original; busy high for 255 cycles.

Source files
------------

// File: rtl/triple_reg_shuffler.sv
// Loads an (a, b, c) word triple, applies one register-transfer op per clock
// for a programmable number of steps, then hands the result downstream.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for a triple; in_ready high, out_* show last result
// S_RUN  | applying the latched op once per edge, counting steps down
// S_DONE | result valid; held until the downstream takes it
module triple_reg_shuffler #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_a_i,
   input  logic [WIDTH-1:0] in_b_i,
   input  logic [WIDTH-1:0] in_c_i,
   input  logic [1:0]       op_i,
   input  logic [CNT_W-1:0] steps_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_a_o,
   output logic [WIDTH-1:0] out_b_o,
   output logic [WIDTH-1:0] out_c_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] step_cnt_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, c_q;
   logic [WIDTH-1:0] a_d, b_d, c_d;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       op_q;

   // All three words are taken from pre-edge values.
   always_comb begin
      a_d = a_q;
      b_d = b_q;
      c_d = c_q;
      unique case (op_q)
         2'b00: begin a_d = b_q; b_d = c_q; c_d = a_q; end
         2'b01: begin a_d = c_q; b_d = a_q; c_d = b_q; end
         2'b10: begin a_d = b_q; b_d = c_q;            end
         2'b11: begin a_d = c_q; c_d = a_q;            end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         cnt_q   <= '0;
         op_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid_i) begin
                  a_q  <= in_a_i;
                  b_q  <= in_b_i;
                  c_q  <= in_c_i;
                  op_q <= op_i;
                  if (steps_i == '0) begin
                     state_q <= S_DONE;
                  end else begin
                     cnt_q   <= steps_i;
                     state_q <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               a_q <= a_d;
               b_q <= b_d;
               c_q <= c_d;
               // <= 1 rather than == 1 so a corrupted zero count cannot wrap
               if (cnt_q <= CNT_W'(1)) begin
                  cnt_q   <= '0;
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_DONE: begin
               if (out_ready_i) state_q <= S_IDLE;
            end
            default: begin
               cnt_q   <= '0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready_o  = (state_q == S_IDLE);
   assign out_valid_o = (state_q == S_DONE);
   assign busy_o      = (state_q == S_RUN);
   assign step_cnt_o  = cnt_q;
   assign out_a_o     = a_q;
   assign out_b_o     = b_q;
   assign out_c_o     = c_q;

endmodule

// File: tb/tb_triple_reg_shuffler.sv
// Directed and randomized transactions against an index-permutation model of
// the triple transfer ops.
module tb_triple_reg_shuffler;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, out_valid, out_ready, busy;
   logic [31:0] in_a, in_b, in_c, out_a, out_b, out_c;
   logic [1:0]  op;
   logic [7:0]  steps, step_cnt;

   int checks = 0;
   int errors = 0;

   // new word i comes from old word src[op][i]
   int src [4][3] = '{'{1, 2, 0}, '{2, 0, 1}, '{1, 2, 2}, '{2, 1, 0}};

   always #5 clk = ~clk;

   triple_reg_shuffler #(.WIDTH(32), .CNT_W(8)) dut (
      .clk_i(clk), .reset_i(reset),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_a_i(in_a), .in_b_i(in_b), .in_c_i(in_c),
      .op_i(op), .steps_i(steps),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_a_o(out_a), .out_b_o(out_b), .out_c_o(out_c),
      .busy_o(busy), .step_cnt_o(step_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_txn(input logic [31:0] a, b, c, input logic [1:0] o,
                          input logic [7:0] n, input int stall);
      logic [31:0] m [3];
      logic [31:0] t [3];
      int edges;
      m[0] = a; m[1] = b; m[2] = c;
      for (int s = 0; s < int'(n); s++) begin
         t = m;
         for (int i = 0; i < 3; i++) m[i] = t[src[o][i]];
      end
      @(negedge clk);
      in_a = a; in_b = b; in_c = c; op = o; steps = n;
      in_valid = 1'b1; out_ready = 1'b0;
      chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      op = ~o; steps = $urandom_range(0, 255);
      edges = 0;
      while (!out_valid && edges < 300) begin
         chk("busy_run", {31'b0, busy}, 32'd1);
         chk("step_cnt_run", {24'b0, step_cnt}, 32'(int'(n) - edges));
         chk("in_ready_run", {31'b0, in_ready}, 32'd0);
         @(posedge clk); #1;
         edges++;
      end
      chk("latency", 32'(edges), 32'(n));
      chk("busy_done", {31'b0, busy}, 32'd0);
      chk("step_cnt_done", {24'b0, step_cnt}, 32'd0);
      chk("out_a", out_a, m[0]);
      chk("out_b", out_b, m[1]);
      chk("out_c", out_c, m[2]);
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_c = $urandom;
         @(posedge clk); #1;
         chk("stall_valid", {31'b0, out_valid}, 32'd1);
         chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
         chk("stall_a", out_a, m[0]);
         chk("stall_b", out_b, m[1]);
         chk("stall_c", out_c, m[2]);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("idle_out_valid", {31'b0, out_valid}, 32'd0);
      chk("idle_in_ready", {31'b0, in_ready}, 32'd1);
      chk("idle_hold_a", out_a, m[0]);
      chk("idle_hold_c", out_c, m[2]);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic chk_triple(input string tag, input logic [31:0] a, b, c);
      chk({tag, "_a"}, out_a, a);
      chk({tag, "_b"}, out_b, b);
      chk({tag, "_c"}, out_c, c);
   endtask

   task automatic chk_reset_state(input string tag);
      chk_triple(tag, 32'd0, 32'd0, 32'd0);
      chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
      chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
      chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
      chk({tag, "_step_cnt"}, {24'b0, step_cnt}, 32'd0);
   endtask

   initial begin
      int guard;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_c = '0; op = '0; steps = '0;
      #1;
      chk_reset_state("reset");
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;

      run_txn(32'd1, 32'd0, 32'd1, 2'b00, 8'd1, 0);
      chk_triple("rotl1", 32'd0, 32'd1, 32'd1);
      run_txn(32'd1, 32'd2, 32'd3, 2'b00, 8'd3, 0);
      chk_triple("rotl3", 32'd1, 32'd2, 32'd3);
      run_txn(32'd1, 32'd2, 32'd3, 2'b01, 8'd1, 1);
      chk_triple("rotr1", 32'd3, 32'd1, 32'd2);
      run_txn(32'd1, 32'd0, 32'd1, 2'b10, 8'd2, 0);
      chk_triple("shift2", 32'd1, 32'd1, 32'd1);
      run_txn(32'd1, 32'd2, 32'd3, 2'b11, 8'd1, 0);
      chk_triple("swap1", 32'd3, 32'd2, 32'd1);
      run_txn(32'd7, 32'd8, 32'd9, 2'b10, 8'd0, 5);
      chk_triple("zero_steps", 32'd7, 32'd8, 32'd9);

      // reset mid-run at step_cnt == 150
      @(negedge clk);
      in_a = 32'd1; in_b = 32'd2; in_c = 32'd3; op = 2'b00; steps = 8'd200;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      guard = 0;
      while (step_cnt != 8'd150 && guard < 300) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("reach_150", {24'b0, step_cnt}, 32'd150);
      #2 reset = 1'b1;
      #1;
      chk_reset_state("mid_reset");
      @(negedge clk) reset = 1'b0;
      run_txn(32'hA, 32'hB, 32'hC, 2'b01, 8'd2, 0);
      chk_triple("post_reset", 32'hB, 32'hC, 32'hA);

      run_txn(32'h11, 32'h22, 32'h33, 2'b00, 8'd255, 0);
      chk_triple("max_steps", 32'h11, 32'h22, 32'h33);

      for (int k = 0; k < 20; k++)
         run_txn($urandom, $urandom, $urandom, 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 12)), $urandom_range(0, 3));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
